// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file slice.
// Holds the default geometry (register count, data and address width) and the
// named encodings for the zero word, the hardwired-zero register address, reset
// polarity, and write/read enable levels. Imported by wb_regfile and
// wb_scoreboard.
package wb_regfile_pkg;

  localparam int REG_NUM_DEF    = 32;
  localparam int REG_WIDTH_DEF  = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic [REG_WIDTH_DEF-1:0]  ZERO_WORD    = '0;
  localparam logic [ADDR_WIDTH_DEF-1:0] NOP_REG_ADDR = '0;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WR_ENABLE    = 1'b1;
  localparam logic WR_DISABLE   = 1'b0;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register load scoreboard.
// A load issuing from ID marks its destination busy; the matching write-back
// clears it. When both hit the same register in one cycle the set wins, since
// the issuing load is younger than the one retiring. Register 0 never becomes
// busy. The busy state of each read port's address is looked up here.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ld_issue, ld_waddr  load issuing this cycle and its destination
//   wb_we, wb_waddr     write-back enable and destination
//   raddr1, raddr2      read-port addresses to look up
//   busy1, busy2        busy bit of raddr1 / raddr2
module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_issue,
  input  logic [ADDR_WIDTH-1:0] ld_waddr,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2
);

  logic [REG_NUM-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < REG_NUM; r++) begin
        // Set is tested first so a same-cycle clear loses to it.
        if (ld_issue && (ld_waddr == ADDR_WIDTH'(r))) begin
          busy[r] <= 1'b1;
        end else if (wb_we && (wb_waddr == ADDR_WIDTH'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign busy1 = busy[raddr1];
  assign busy2 = busy[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// General-purpose register file fed by the MEM_WB write-back port.
// Two combinational read ports serve ID; register 0 reads as zero and ignores
// writes. A load scoreboard (wb_scoreboard) drives the load-use stall request.
// Optional feature macro: WB_BYPASS_EN -- when defined, a write-back hitting an
// enabled read address is forwarded to that port in the same cycle, and a busy
// register being written this cycle no longer stalls its reader.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   wb_waddr, wb_we, wb_wdata  write-back from MEM_WB
//   re1/raddr1/rdata1          read port 1 (enable, address, data)
//   re2/raddr2/rdata2          read port 2 (enable, address, data)
//   ld_issue, ld_waddr         load issuing from ID and its destination
//   stall_req                  load-use hazard on an enabled read port
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM    = REG_NUM_DEF,
  parameter int REG_WIDTH  = REG_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic                  wb_we,
  input  logic [REG_WIDTH-1:0]  wb_wdata,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [REG_WIDTH-1:0]  rdata1,
  input  logic                  re2,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [REG_WIDTH-1:0]  rdata2,
  input  logic                  ld_issue,
  input  logic [ADDR_WIDTH-1:0] ld_waddr,
  output logic                  stall_req
);

`ifdef WB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  logic [REG_WIDTH-1:0] regs [REG_NUM];
  logic                 busy1;
  logic                 busy2;
  logic                 act1;
  logic                 act2;
  logic                 hit1;
  logic                 hit2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if ((wb_we == WR_ENABLE) && (wb_waddr != '0)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

  wb_scoreboard #(
    .REG_NUM    (REG_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ld_issue (ld_issue),
    .ld_waddr (ld_waddr),
    .wb_we    (wb_we),
    .wb_waddr (wb_waddr),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  // A port is active when enabled on a nonzero register; only active ports
  // return data, bypass, or stall.
  assign act1 = (re1 == READ_ENABLE) && (raddr1 != '0);
  assign act2 = (re2 == READ_ENABLE) && (raddr2 != '0);

  // Write-back hit on an active port; only meaningful when bypass is built in.
  assign hit1 = BYPASS && act1 && wb_we && (wb_waddr == raddr1);
  assign hit2 = BYPASS && act2 && wb_we && (wb_waddr == raddr2);

  // Outputs are forced to zero while reset is held so nothing from the
  // write-back port leaks through the bypass during reset.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst != RST_ENABLE) begin
      if (hit1) begin
        rdata1 = wb_wdata;
      end else if (act1) begin
        rdata1 = regs[raddr1];
      end
      if (hit2) begin
        rdata2 = wb_wdata;
      end else if (act2) begin
        rdata2 = regs[raddr2];
      end
    end
  end

  // A reader of a busy register stalls unless the load's data is being
  // forwarded to it this very cycle.
  assign stall_req = (rst != RST_ENABLE) &&
                     ((act1 && busy1 && !hit1) || (act2 && busy2 && !hit2));

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wb_waddr = '0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_waddr = '0;
  logic        stall_req;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model: architectural register contents and pending-load set.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb_waddr  (wb_waddr),
    .wb_we     (wb_we),
    .wb_wdata  (wb_wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .ld_issue  (ld_issue),
    .ld_waddr  (ld_waddr),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 32'h0;
    if (BYP && wb_we && wb_waddr == ra) return wb_wdata;
    return m_regs[ra];
  endfunction

  function automatic logic port_stall(input logic re, input logic [4:0] ra);
    if (rst || !re || ra == 5'd0) return 1'b0;
    if (!m_busy[ra]) return 1'b0;
    return !(BYP && wb_we && wb_waddr == ra);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_update();
    if (rst) begin
      model_clear();
    end else begin
      if (wb_we && wb_waddr != 5'd0) begin
        m_regs[wb_waddr] = wb_wdata;
        m_busy[wb_waddr] = 1'b0;
      end
      if (ld_issue && ld_waddr != 5'd0) m_busy[ld_waddr] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    ld_issue = 1'b0; ld_waddr = '0;
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata1", rdata1, exp_rd(re1, raddr1));
      chk("rdata2", rdata2, exp_rd(re2, raddr2));
      chk("stall_req", {31'h0, stall_req},
          {31'h0, port_stall(re1, raddr1) | port_stall(re2, raddr2)});
    end
  end

  initial begin
    model_clear();
    idle();
    // Reset held: outputs are zero even with a read enabled.
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    step();
    step();
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle();

    // 1. All registers read zero after reset.
    for (int r = 1; r < 32; r++) begin
      re1 = 1'b1; raddr1 = 5'(r);
      #2;
      chk("t1_zero", rdata1, 32'h0);
      chk("t1_stall", {31'h0, stall_req}, 32'h0);
      step();
    end
    idle();

    // 2. Write then read next cycle; write to r0 dropped.
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF;
    step();
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h00001234;
    #2;
    chk("t2_r5", rdata1, 32'hDEADBEEF);
    step();
    idle();
    re2 = 1'b1; raddr2 = 5'd0;
    #2;
    chk("t2_r0", rdata2, 32'h0);
    step();

    // 3. Same-cycle bypass of a write-back.
    idle();
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h11111111;
    step();
    wb_wdata = 32'hA5A5A5A5; re1 = 1'b1; raddr1 = 5'd7;
    #2;
    chk("t3_bypass", rdata1, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    step();
    idle();
    re1 = 1'b1; raddr1 = 5'd7;
    #2;
    chk("t3_after", rdata1, 32'hA5A5A5A5);
    step();

    // 4. Load-use stall until the write-back of r9.
    idle();
    ld_issue = 1'b1; ld_waddr = 5'd9;
    step();
    idle();
    re2 = 1'b1; raddr2 = 5'd9;
    #2;
    chk("t4_stall_a", {31'h0, stall_req}, 32'h1);
    step();
    #2;
    chk("t4_stall_b", {31'h0, stall_req}, 32'h1);
    step();
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h00000099;
    #2;
    chk("t4_wb_cycle", {31'h0, stall_req}, BYP ? 32'h0 : 32'h1);
    step();
    wb_we = 1'b0;
    #2;
    chk("t4_after", {31'h0, stall_req}, 32'h0);
    chk("t4_data", rdata2, 32'h00000099);
    step();

    // 5. Set and clear of r3 in the same cycle: set wins.
    idle();
    ld_issue = 1'b1; ld_waddr = 5'd3;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h00000033;
    step();
    idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #2;
    chk("t5_stall", {31'h0, stall_req}, 32'h1);
    step();
    idle();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h00000333;
    step();
    idle();

    // 6. Async reset pulse between edges with r4 busy and r4 = 0x55.
    ld_issue = 1'b1; ld_waddr = 5'd4;
    wb_we = 1'b1; wb_waddr = 5'd4; wb_wdata = 32'h00000055;
    step();
    idle();
    re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4;
    #1;
    chk("t6_pre_stall", {31'h0, stall_req}, 32'h1);
    chk("t6_pre_data", rdata1, 32'h00000055);
    rst = 1'b1;
    #1;
    chk("t6_rst_data1", rdata1, 32'h0);
    chk("t6_rst_data2", rdata2, 32'h0);
    chk("t6_rst_stall", {31'h0, stall_req}, 32'h0);
    model_clear();
    #1;
    rst = 1'b0;
    step();
    #2;
    chk("t6_post_stall", {31'h0, stall_req}, 32'h0);
    chk("t6_post_data", rdata1, 32'h0);
    step();

    // Randomized traffic, biased toward a few registers to provoke hazards,
    // with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wb_we    = $urandom_range(0, 1);
      wb_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      re1      = ($urandom_range(0, 3) != 0);
      raddr1   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      re2      = ($urandom_range(0, 3) != 0);
      raddr2   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_waddr = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    idle();
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
